cond_unit_mc: RTL and testbench
===============================

COND_UNIT_MC -- requirements
Module: cond_unit_mc

Interface
REQ-001 SHALL have parameter NUM_CTX, default 4, number of independent flag contexts (1..16).
REQ-002 SHALL have parameter CNT_W, default 32, width of the statistics counters.
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset (0 = reset, sampled on rising clk).
REQ-005 SHALL have port in_valid, input, 1, instruction present this cycle.
REQ-006 SHALL have port in_ctx, input, $clog2(NUM_CTX) (min 1), flag context selector.
REQ-007 SHALL have port Cond, input, 4, condition field.
REQ-008 SHALL have port ALUFlags, input, 4, {N,Z,C,V} from the ALU, bit3 = N.
REQ-009 SHALL have port FlagW, input, 2, bit1 = write N,Z; bit0 = write C,V.
REQ-010 SHALL have ports PCS_in, RegW_in, MemW_in, input, 1 each, unconditioned decoder controls.
REQ-011 SHALL have ports stall, flush, input, 1 each, pipeline hold and squash.
REQ-012 SHALL have ports PCSrc, RegWrite, MemWrite, output, 1 each, registered conditioned controls.
REQ-013 SHALL have port out_valid, output, 1, registered: an instruction was evaluated last accepted cycle.
REQ-014 SHALL have port cond_nv, output, 1, registered pulse: accepted instruction had Cond = 1111.
REQ-015 SHALL have ports exec_count, skip_count, output, CNT_W each, executed / condition-failed instruction counts.

Function
REQ-016 SHALL hold one 4-bit flag register per context; the accepted instruction reads only Flags[in_ctx].
REQ-017 SHALL accept an instruction when in_valid=1, stall=0, flush=0.
REQ-018 SHALL compute condex combinationally from Flags[in_ctx] in the accept cycle: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 0.
REQ-019 SHALL update Flags[in_ctx] at end of the accept cycle only if condex=1: N,Z from ALUFlags when FlagW[1]; C,V when FlagW[0]; other contexts and unselected fields unchanged.
REQ-020 SHALL give latency 1: on the edge after acceptance, out_valid=1, PCSrc=PCS_in&condex, RegWrite=RegW_in&condex, MemWrite=MemW_in&condex, cond_nv=(Cond==1111).
REQ-021 SHALL let a same-context instruction accepted the next cycle see flags written by its predecessor (no bubble).
REQ-022 SHALL, when stall=1 and flush=0, hold all outputs and counters and leave flags unchanged.
REQ-023 SHALL, when flush=1 (priority over stall and in_valid), drive out_valid, PCSrc, RegWrite, MemWrite, cond_nv to 0 on the next edge, with no flag or counter update.
REQ-024 SHALL, when in_valid=0, stall=0, flush=0, drive all registered controls and out_valid to 0 on the next edge.
REQ-025 SHALL increment exec_count on acceptance with condex=1, skip_count on acceptance with condex=0 (includes 1111); both wrap modulo 2^CNT_W.
REQ-026 SHALL treat in_ctx >= NUM_CTX as context 0.

Reset
REQ-027 SHALL, while reset=0 at a rising edge, clear all flag registers to 0000, all registered outputs to 0, and both counters to 0.
REQ-028 SHALL let reset override stall, flush and in_valid; an instruction presented during reset is discarded.
REQ-029 SHALL accept instructions from the first edge with reset=1.

Structure
REQ-030 SHALL take from shared package cond_pkg: cond_e enum (EQ..AL, NV), flag bit indices FLAG_N/Z/C/V, flags_t 4-bit type.
REQ-031 SHALL place condition evaluation in combinational sub-module cond_check (inputs Cond, flags; output condex), reusable elsewhere.
REQ-032 SHALL contain no latches; debug display statements are excluded from synthesisable code.

Verification
REQ-033 SHALL cover: reset, then ctx0 CMP-like FlagW=11 ALUFlags=0100 Cond=AL, next cycle ctx0 Cond=EQ RegW_in=1 -> RegWrite=1 one cycle later, exec_count=2.
REQ-034 SHALL cover: ctx1 Flags=0000, Cond=NE PCS_in=1 then ctx2 Cond=EQ PCS_in=1 -> PCSrc 1 then 0, skip_count=1, ctx1 flags untouched.
REQ-035 SHALL cover: FlagW=10 ALUFlags=1011 on cleared ctx0 -> Flags[ctx0]=1000 (C,V unchanged); Cond=EQ with FlagW=11 failing -> flags unchanged.
REQ-036 SHALL cover: accept Cond=AL MemW_in=1, then stall=1 for 3 cycles -> MemWrite held 1 for 4 cycles, counters frozen; flush with stall -> all outputs 0 next edge.
REQ-037 SHALL cover: Cond=1111 PCS_in=1 -> PCSrc=0, cond_nv=1 one cycle, skip_count+1; CNT_W=4 with 16 executions -> exec_count wraps to 0.
REQ-038 SHALL cover: reset=0 asserted mid-stream with in_valid=1 -> next edge all outputs, flags, counters 0; no instruction effect.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared condition-code definitions: ARM-style condition encodings and NZCV flag layout.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] flags_t;

endpackage

// File: rtl/cond_check.sv
// Pure combinational condition evaluator: decides whether Cond passes against an NZCV flag set.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  flags_t     flags,
  output logic       condex
);

  logic n, z, c, v;

  always_comb begin
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    c = flags[FLAG_C];
    v = flags[FLAG_V];
    condex = 1'b0;
    case (cond_e'(Cond))
      EQ: condex = z;
      NE: condex = ~z;
      CS: condex = c;
      CC: condex = ~c;
      MI: condex = n;
      PL: condex = ~n;
      VS: condex = v;
      VC: condex = ~v;
      HI: condex = c & ~z;
      LS: condex = ~c | z;
      GE: condex = (n == v);
      LT: condex = (n != v);
      GT: condex = ~z & (n == v);
      LE: condex = z | (n != v);
      AL: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit_mc.sv
// Multi-context conditional-execution unit: per-context NZCV flags, conditioned controls
// registered one cycle after acceptance, and executed/skipped statistics.
module cond_unit_mc
  import cond_pkg::*;
#(
  parameter int NUM_CTX = 4,
  parameter int CNT_W   = 32,
  localparam int CTX_W  = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [CTX_W-1:0] in_ctx,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS_in,
  input  logic             RegW_in,
  input  logic             MemW_in,
  input  logic             stall,
  input  logic             flush,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             out_valid,
  output logic             cond_nv,
  output logic [CNT_W-1:0] exec_count,
  output logic [CNT_W-1:0] skip_count
);

  flags_t           flags [NUM_CTX];
  logic [CTX_W-1:0] ctx;
  flags_t           cur_flags;
  flags_t           nxt_flags;
  logic             condex;

  // Out-of-range selectors alias context 0 so a bad ctx can never touch unbacked state.
  always_comb begin
    ctx = '0;
    if (32'(in_ctx) < NUM_CTX) ctx = in_ctx;
    cur_flags = flags[ctx];
    nxt_flags = cur_flags;
    if (FlagW[1]) begin
      nxt_flags[FLAG_N] = ALUFlags[FLAG_N];
      nxt_flags[FLAG_Z] = ALUFlags[FLAG_Z];
    end
    if (FlagW[0]) begin
      nxt_flags[FLAG_C] = ALUFlags[FLAG_C];
      nxt_flags[FLAG_V] = ALUFlags[FLAG_V];
    end
  end

  cond_check u_cond_check (
    .Cond   (Cond),
    .flags  (cur_flags),
    .condex (condex)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CTX; i++) flags[i] <= '0;
      {out_valid, PCSrc, RegWrite, MemWrite, cond_nv} <= '0;
      exec_count <= '0;
      skip_count <= '0;
    end else if (flush) begin
      {out_valid, PCSrc, RegWrite, MemWrite, cond_nv} <= '0;
    end else if (!stall) begin
      out_valid <= in_valid;
      PCSrc     <= in_valid & PCS_in  & condex;
      RegWrite  <= in_valid & RegW_in & condex;
      MemWrite  <= in_valid & MemW_in & condex;
      cond_nv   <= in_valid & (Cond == NV);
      if (in_valid) begin
        if (condex) begin
          flags[ctx] <= nxt_flags;
          exec_count <= exec_count + CNT_W'(1);
        end else begin
          skip_count <= skip_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cond_unit_mc.sv
// Directed bench for cond_unit_mc: hand-computed expectations for flags, controls, stall/flush and counters.
module tb_cond_unit_mc;
  import cond_pkg::*;

  localparam int NUM_CTX = 3;
  localparam int CNT_W   = 4;
  localparam int CTX_W   = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [CTX_W-1:0] in_ctx;
  logic [3:0]       Cond, ALUFlags;
  logic [1:0]       FlagW;
  logic             PCS_in, RegW_in, MemW_in, stall, flush;
  logic             PCSrc, RegWrite, MemWrite, out_valid, cond_nv;
  logic [CNT_W-1:0] exec_count, skip_count;

  int n_chk  = 0;
  int n_fail = 0;

  cond_unit_mc #(.NUM_CTX(NUM_CTX), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctx(in_ctx), .Cond(Cond),
    .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS_in(PCS_in), .RegW_in(RegW_in),
    .MemW_in(MemW_in), .stall(stall), .flush(flush), .PCSrc(PCSrc),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .out_valid(out_valid),
    .cond_nv(cond_nv), .exec_count(exec_count), .skip_count(skip_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    in_valid = 0; in_ctx = 0; Cond = 4'hE; ALUFlags = 0; FlagW = 0;
    PCS_in = 0; RegW_in = 0; MemW_in = 0; stall = 0; flush = 0;
  endtask

  task automatic issue(input logic [1:0] ctx, input logic [3:0] cnd, input logic [3:0] alu,
                       input logic [1:0] fw, input logic pcs, input logic rw, input logic mw);
    clr_in();
    in_valid = 1; in_ctx = ctx; Cond = cnd; ALUFlags = alu; FlagW = fw;
    PCS_in = pcs; RegW_in = rw; MemW_in = mw;
    step();
  endtask

  // {out_valid, PCSrc, RegWrite, MemWrite, cond_nv}
  task automatic chk_out(input string tag, input logic [4:0] exp, input int ex, input int sk);
    chk({tag, ".ctl"}, {27'd0, out_valid, PCSrc, RegWrite, MemWrite, cond_nv}, {27'd0, exp});
    chk({tag, ".exec"}, 32'(exec_count), 32'(ex));
    chk({tag, ".skip"}, 32'(skip_count), 32'(sk));
  endtask

  initial begin
    clr_in();
    reset = 0;
    step(); step();
    chk_out("reset", 5'b00000, 0, 0);
    reset = 1;

    // CMP-like flag set then same-context EQ sees it immediately
    issue(0, 4'hE, 4'b0100, 2'b11, 0, 0, 0); chk_out("cmp", 5'b10000, 1, 0);
    issue(0, 4'h0, 4'b0000, 2'b00, 0, 1, 0); chk_out("eq_fwd", 5'b10100, 2, 0);

    // Context isolation
    issue(1, 4'h1, 4'b0000, 2'b00, 1, 0, 0); chk_out("c1_ne", 5'b11000, 3, 0);
    issue(2, 4'h0, 4'b0100, 2'b11, 1, 0, 0); chk_out("c2_eq_fail", 5'b10000, 3, 1);
    issue(2, 4'h1, 4'b0000, 2'b00, 1, 0, 0); chk_out("c2_ne_unch", 5'b11000, 4, 1);
    issue(1, 4'h0, 4'b0000, 2'b00, 1, 0, 0); chk_out("c1_untouch", 5'b10000, 4, 2);
    // ctx 3 is out of range and aliases ctx0 (Z=1)
    issue(3, 4'h0, 4'b0000, 2'b00, 0, 1, 0); chk_out("ctx_alias", 5'b10100, 5, 2);

    // Mid-stream reset with a live instruction that would set all flags
    clr_in();
    reset = 0; in_valid = 1; Cond = 4'hE; ALUFlags = 4'b1111; FlagW = 2'b11; MemW_in = 1;
    step();
    chk_out("mid_reset", 5'b00000, 0, 0);
    reset = 1;
    issue(0, 4'h0, 4'b0000, 2'b00, 0, 1, 0); chk_out("post_rst_eq", 5'b10000, 0, 1);

    // Partial flag write: only N,Z
    issue(0, 4'hE, 4'b1011, 2'b10, 0, 0, 0); chk_out("fw10", 5'b10000, 1, 1);
    issue(0, 4'h4, 4'b0000, 2'b00, 0, 1, 0); chk_out("mi", 5'b10100, 2, 1);
    issue(0, 4'h2, 4'b0000, 2'b00, 0, 1, 0); chk_out("cs_keep", 5'b10000, 2, 2);
    issue(0, 4'h6, 4'b0000, 2'b00, 0, 1, 0); chk_out("vs_keep", 5'b10000, 2, 3);
    issue(0, 4'h0, 4'b0100, 2'b11, 0, 1, 0); chk_out("eq_nowr", 5'b10000, 2, 4);
    issue(0, 4'h5, 4'b0000, 2'b00, 0, 1, 0); chk_out("pl", 5'b10000, 2, 5);
    issue(0, 4'h1, 4'b0000, 2'b00, 0, 1, 0); chk_out("ne", 5'b10100, 3, 5);

    // ctx1 = N=1,V=1,Z=0,C=0: signed compares
    issue(1, 4'hE, 4'b1001, 2'b11, 0, 0, 0); chk_out("c1_set", 5'b10000, 4, 5);
    issue(1, 4'hA, 4'b0000, 2'b00, 0, 1, 0); chk_out("ge", 5'b10100, 5, 5);
    issue(1, 4'hB, 4'b0000, 2'b00, 0, 1, 0); chk_out("lt", 5'b10000, 5, 6);
    issue(1, 4'hC, 4'b0000, 2'b00, 0, 1, 0); chk_out("gt", 5'b10100, 6, 6);
    issue(1, 4'hD, 4'b0000, 2'b00, 0, 1, 0); chk_out("le", 5'b10000, 6, 7);
    issue(1, 4'h8, 4'b0000, 2'b00, 0, 1, 0); chk_out("hi", 5'b10000, 6, 8);
    issue(1, 4'h9, 4'b0000, 2'b00, 0, 1, 0); chk_out("ls", 5'b10100, 7, 8);

    // Stall holds outputs and counters; flush wins over stall
    issue(0, 4'hE, 4'b0000, 2'b00, 0, 0, 1); chk_out("mw", 5'b10010, 8, 8);
    for (int i = 0; i < 3; i++) begin
      clr_in(); in_valid = 1; stall = 1; Cond = 4'hE; PCS_in = 1; FlagW = 2'b11; ALUFlags = 4'b0100;
      step();
      chk_out($sformatf("stall%0d", i), 5'b10010, 8, 8);
    end
    clr_in(); in_valid = 1; stall = 1; flush = 1; Cond = 4'hE; PCS_in = 1;
    step();
    chk_out("flush", 5'b00000, 8, 8);
    // stalled/flushed CMP must not have set Z on ctx0 (still N=1,Z=0)
    issue(0, 4'h0, 4'b0000, 2'b00, 0, 1, 0); chk_out("no_stall_wr", 5'b10000, 8, 9);
    clr_in(); step();
    chk_out("idle", 5'b00000, 8, 9);

    // Never condition
    issue(0, 4'hF, 4'b0000, 2'b00, 1, 0, 0); chk_out("nv", 5'b10001, 8, 10);
    clr_in(); step();
    chk_out("nv_pulse", 5'b00000, 8, 10);

    // 4-bit counter wrap after 16 executions
    reset = 0; step(); reset = 1;
    for (int i = 0; i < 15; i++) issue(0, 4'hE, 4'b0000, 2'b00, 0, 0, 0);
    chk_out("cnt15", 5'b10000, 15, 0);
    issue(0, 4'hE, 4'b0000, 2'b00, 0, 0, 0);
    chk_out("cnt_wrap", 5'b10000, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
